// File: rtl/mem_req_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single AXI4-Lite style master.
// Default policy is data-priority with instruction starvation guard; define ARB_ROUND_ROBIN_EN for round-robin.
module mem_req_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_error,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_error,
    output logic        m_req,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    input  logic        m_error,
    output logic        grant_d,
    output logic        busy
);
    // Handshake: x_req is held with a stable payload until the one-cycle x_ready pulse;
    // m_req is a one-cycle pulse and the single m_ready pulse in WAIT completes the transfer.

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state_q;
    logic        grant_d_q;
    logic        m_req_q;
    logic        m_wr_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic [3:0]  m_wstrb_q;
    logic [31:0] i_rdata_q;
    logic        i_ready_q;
    logic        i_error_q;
    logic [31:0] d_rdata_q;
    logic        d_ready_q;
    logic        d_error_q;
    logic        pick_data;

`ifdef ARB_ROUND_ROBIN_EN
    // grant_d_q doubles as the last-owner flag; it resets to instruction.
    always_comb begin
        pick_data = d_req;
        if (i_req && d_req)
            pick_data = ~grant_d_q;
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_q;

    always_comb begin
        pick_data = d_req;
        if (i_req && d_req)
            pick_data = (starve_q != LIMIT);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_d_q <= 1'b0;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            m_wstrb_q <= 4'd0;
            i_rdata_q <= 32'd0;
            i_ready_q <= 1'b0;
            i_error_q <= 1'b0;
            d_rdata_q <= 32'd0;
            d_ready_q <= 1'b0;
            d_error_q <= 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
            starve_q  <= 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_q   <= ISSUE;
                        m_req_q   <= 1'b1;
                        grant_d_q <= pick_data;
                        if (pick_data) begin
                            m_wr_q    <= d_wr;
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                            m_wstrb_q <= d_wstrb;
                        end else begin
                            m_wr_q    <= 1'b0;
                            m_addr_q  <= i_addr;
                            m_wdata_q <= 32'd0;
                            m_wstrb_q <= 4'b1111;
                        end
`ifndef ARB_ROUND_ROBIN_EN
                        // Count data grants that overtook a waiting instruction fetch.
                        if (!pick_data)
                            starve_q <= 4'd0;
                        else if (i_req && starve_q != LIMIT)
                            starve_q <= starve_q + 4'd1;
`endif
                    end
                end
                ISSUE: begin
                    m_req_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (m_ready) begin
                        state_q <= DONE;
                        if (grant_d_q) begin
                            d_rdata_q <= m_rdata;
                            d_error_q <= m_error;
                            d_ready_q <= 1'b1;
                        end else begin
                            i_rdata_q <= m_rdata;
                            i_error_q <= m_error;
                            i_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    i_ready_q <= 1'b0;
                    i_error_q <= 1'b0;
                    d_ready_q <= 1'b0;
                    d_error_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_req   = m_req_q;
    assign m_wr    = m_wr_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign i_rdata = i_rdata_q;
    assign i_ready = i_ready_q;
    assign i_error = i_error_q;
    assign d_rdata = d_rdata_q;
    assign d_ready = d_ready_q;
    assign d_error = d_error_q;
    assign grant_d = grant_d_q;
    assign busy    = (state_q != IDLE);

endmodule
